// File: rtl/fmltg_pkg.sv
// fmltg_pkg: shared state encoding, CSR word indices and burst geometry
package fmltg_pkg;
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DATA, S_DRAIN} state_t;
    localparam logic [2:0] REG_CTRL   = 3'd0;
    localparam logic [2:0] REG_BASE   = 3'd1;
    localparam logic [2:0] REG_COUNT  = 3'd2;
    localparam logic [2:0] REG_SEED   = 3'd3;
    localparam logic [2:0] REG_ERRORS = 3'd4;
    localparam logic [2:0] REG_CYCLES = 3'd5;
    localparam int BURST_LEN   = 4;
    localparam int BURST_BYTES = 32;
endpackage

// File: rtl/fmltg_pattern.sv
// fmltg_pattern: deterministic beat data {w, ~w}, w = seed ^ (addr + 8*beat)
module fmltg_pattern #(
    parameter int adr_width = 26
) (
    input  logic [31:0]          i_seed,
    input  logic [adr_width-1:0] i_adr,
    input  logic [1:0]           i_beat,
    output logic [63:0]          o_data
);
    logic [31:0] w_word;
    assign w_word = i_seed ^ (32'(i_adr) + {27'd0, i_beat, 3'd0});
    assign o_data = {w_word, ~w_word};
endmodule

// File: rtl/fmltg.sv
// fmltg: CSR-programmed FML initiator issuing 4-beat pattern write bursts or
// checked read bursts for memory bring-up and bandwidth measurement.
module fmltg
    import fmltg_pkg::*;
#(
    parameter logic [3:0] csr_addr  = 4'h0,
    parameter int         adr_width = 26
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst_n,
    input  logic [14:0]          csr_a,
    input  logic                 csr_we,
    input  logic [31:0]          csr_di,
    output logic [31:0]          csr_do,
    output logic [adr_width-1:0] fml_adr,
    output logic                 fml_stb,
    output logic                 fml_we,
    output logic [7:0]           fml_sel,
    output logic [63:0]          fml_do,
    input  logic                 fml_ack,
    input  logic [63:0]          fml_di
);
    state_t               r_state, w_next;
    logic                 r_mode, r_abort, r_drain, r_chk;
    logic [adr_width-1:0] r_base, r_adr;
    logic [31:0]          r_count, r_left, r_seed, r_errors, r_cycles, w_rd;
    logic [1:0]           r_beat, w_next_beat;
    logic [63:0]          w_pat, r_exp, r_exp_q, r_di;
    logic                 w_sel, w_busy, w_cfg_we, w_ctrl_we, w_start, w_abort, w_last_beat;
    logic                 w_unused;

    assign w_unused    = ^csr_a[9:3];
    assign w_sel       = csr_a[14:10] == {1'b0, csr_addr};
    assign w_busy      = r_state != S_IDLE;
    assign w_cfg_we    = w_sel && csr_we && !w_busy;
    assign w_ctrl_we   = w_sel && csr_we && csr_a[2:0] == REG_CTRL;
    assign w_abort     = w_ctrl_we && csr_di[2];
    assign w_start     = w_ctrl_we && csr_di[0] && !csr_di[2] && !w_busy && r_count != 32'd0;
    assign w_last_beat = r_state == S_DATA && r_beat == 2'(BURST_LEN - 1);
    assign w_next_beat = r_state == S_DATA ? r_beat + 2'd1 : 2'd0;

    assign fml_stb = r_state == S_REQ;
    assign fml_we  = r_mode;
    assign fml_adr = r_adr;

    // Pattern for the beat about to be presented; its registered copy is
    // both the write data source and the read compare reference.
    fmltg_pattern #(.adr_width(adr_width)) u_pattern (
        .i_seed (r_seed),
        .i_adr  (r_adr),
        .i_beat (w_next_beat),
        .o_data (w_pat)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = w_start ? S_REQ : S_IDLE;
            S_REQ:   w_next = fml_ack ? S_DATA : (w_abort ? S_DRAIN : S_REQ);
            S_DATA:  w_next = !w_last_beat ? S_DATA :
                              (r_abort || w_abort || r_left == 32'd1) ? S_DRAIN : S_REQ;
            S_DRAIN: w_next = r_drain ? S_IDLE : S_DRAIN;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_rd = '0;
        case (csr_a[2:0])
            REG_CTRL:   w_rd = {30'd0, r_mode, w_busy};
            REG_BASE:   w_rd = 32'(r_base);
            REG_COUNT:  w_rd = r_count;
            REG_SEED:   w_rd = r_seed;
            REG_ERRORS: w_rd = r_errors;
            REG_CYCLES: w_rd = r_cycles;
            default:    w_rd = '0;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) r_state <= S_IDLE;
        else            r_state <= w_next;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            csr_do   <= '0;
            r_mode   <= 1'b0;
            r_base   <= '0;
            r_count  <= '0;
            r_seed   <= '0;
            r_errors <= '0;
            r_cycles <= '0;
            r_adr    <= '0;
            r_left   <= '0;
            r_abort  <= 1'b0;
            r_beat   <= '0;
            r_drain  <= 1'b0;
            fml_do   <= '0;
            fml_sel  <= '0;
            r_exp    <= '0;
            r_exp_q  <= '0;
            r_di     <= '0;
            r_chk    <= 1'b0;
        end else begin
            csr_do <= w_sel ? w_rd : '0;
            if (w_cfg_we && csr_a[2:0] == REG_BASE)  r_base  <= {csr_di[adr_width-1:5], 5'd0};
            if (w_cfg_we && csr_a[2:0] == REG_COUNT) r_count <= csr_di;
            if (w_cfg_we && csr_a[2:0] == REG_SEED)  r_seed  <= csr_di;
            if (w_ctrl_we && !w_busy)                r_mode  <= csr_di[1];
            if (w_start) begin
                r_adr    <= r_base;
                r_left   <= r_count;
                r_errors <= '0;
                r_cycles <= '0;
                r_abort  <= 1'b0;
            end else begin
                if (w_busy) r_cycles <= r_cycles + 32'd1;
                if (w_busy && w_abort) r_abort <= 1'b1;
                if (w_last_beat) begin
                    r_adr  <= r_adr + adr_width'(BURST_BYTES);
                    r_left <= r_left - 32'd1;
                end
                if (r_chk && r_di != r_exp_q && r_errors != '1) r_errors <= r_errors + 32'd1;
            end
            r_beat  <= w_next_beat;
            r_drain <= r_state == S_DRAIN && !r_drain;
            fml_do  <= (w_next == S_DATA && r_mode) ? w_pat : '0;
            fml_sel <= (w_next == S_DATA && r_mode) ? 8'hFF : 8'h00;
            r_exp   <= w_pat;
            r_exp_q <= r_exp;
            r_di    <= fml_di;
            r_chk   <= r_state == S_DATA && !r_mode;
        end
    end
endmodule

// File: tb/tb_fmltg.sv
// tb_fmltg: scoreboard bench; a memory responder pops expected requests/beats
// from queues filled by the scenario tasks.
module tb_fmltg;
    import fmltg_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [14:0] csr_a = '0;
    logic        csr_we = 1'b0;
    logic [31:0] csr_di = '0;
    logic [31:0] csr_do;
    logic [25:0] fml_adr;
    logic        fml_stb, fml_we, fml_ack;
    logic [7:0]  fml_sel;
    logic [63:0] fml_do, fml_di;

    int          checks = 0, errors = 0;
    int          ack_lat = 1, stb_cycles = 0, gbeat = 0, cyc = 0;
    logic        rd_mode = 1'b0;
    logic [31:0] seed_tb = '0;
    logic [63:0] corrupt = '0;
    logic [25:0] q_req[$];
    logic [63:0] q_wr[$];
    int          ack_cyc[$];

    fmltg dut (
        .sys_clk(clk), .sys_rst_n(rst_n), .csr_a(csr_a), .csr_we(csr_we), .csr_di(csr_di),
        .csr_do(csr_do), .fml_adr(fml_adr), .fml_stb(fml_stb), .fml_we(fml_we),
        .fml_sel(fml_sel), .fml_do(fml_do), .fml_ack(fml_ack), .fml_di(fml_di)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] pat(input logic [31:0] s, input logic [25:0] a, input int k);
        logic [31:0] w;
        w = s ^ ({6'd0, a} + 32'(8 * k));
        return {w, ~w};
    endfunction

    // Memory model: acks after ack_lat strobe cycles, then owns 4 beat cycles.
    initial begin
        int wait_cnt, beat_left, k;
        logic [25:0] cur_adr;
        logic [63:0] exp;
        wait_cnt = 0; beat_left = 0; cur_adr = '0;
        fml_ack = 1'b0; fml_di = '0;
        forever begin
            @(posedge clk); #1;
            cyc++;
            fml_ack = 1'b0;
            fml_di = '0;
            if (!rst_n) begin
                wait_cnt = 0; beat_left = 0;
            end else if (beat_left > 0) begin
                k = 4 - beat_left;
                if (rd_mode) begin
                    fml_di = pat(seed_tb, cur_adr, k) ^ ((gbeat < 64 && corrupt[gbeat]) ? 64'h1 : 64'h0);
                    checks++;
                    if (fml_sel !== 8'h00) begin
                        errors++; $display("FAIL rd_sel beat %0d: got %h want 00", gbeat, fml_sel);
                    end
                end else if (q_wr.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_beat %0d: got do=%h want none", gbeat, fml_do);
                end else begin
                    exp = q_wr.pop_front();
                    checks++;
                    if (fml_do !== exp || fml_sel !== 8'hFF) begin
                        errors++;
                        $display("FAIL wr_beat %0d: got do=%h sel=%h want do=%h sel=ff", gbeat, fml_do, fml_sel, exp);
                    end
                end
                gbeat++;
                beat_left--;
            end else if (fml_stb) begin
                stb_cycles++;
                wait_cnt++;
                if (wait_cnt >= ack_lat) begin
                    fml_ack = 1'b1; wait_cnt = 0; beat_left = 4;
                    ack_cyc.push_back(cyc);
                    checks++;
                    if (q_req.size() == 0) begin
                        errors++; $display("FAIL unexpected_req: got adr=%h want none", fml_adr);
                    end else begin
                        cur_adr = q_req.pop_front();
                        if (fml_adr !== cur_adr || fml_we !== !rd_mode) begin
                            errors++;
                            $display("FAIL req: got adr=%h we=%b want adr=%h we=%b", fml_adr, fml_we, cur_adr, !rd_mode);
                        end
                    end
                end
            end else wait_cnt = 0;
        end
    end

    task csr_write(input logic [2:0] idx, input logic [31:0] d);
        csr_a = {12'd0, idx}; csr_di = d; csr_we = 1'b1;
        @(posedge clk); #1;
        csr_we = 1'b0;
    endtask

    task csr_read(input logic [2:0] idx, output logic [31:0] d);
        csr_a = {12'd0, idx}; csr_we = 1'b0;
        @(posedge clk); #1;
        d = csr_do;
    endtask

    task wait_idle;
        logic [31:0] d;
        int n;
        d = 32'h1; n = 0;
        while (d[0] && n < 200) begin
            csr_read(REG_CTRL, d);
            n++;
        end
        checks++;
        if (d[0]) begin
            errors++; $display("FAIL busy_timeout: got busy=1 want 0 within 200 cycles");
        end
    endtask

    task prep(input int lat, input logic rd, input logic [31:0] seed);
        ack_lat = lat; rd_mode = rd; seed_tb = seed;
        stb_cycles = 0; gbeat = 0; corrupt = '0;
        ack_cyc.delete();
    endtask

    task test_reset;
        logic [31:0] d;
        checks++;
        if (fml_stb !== 1'b0 || fml_we !== 1'b0 || fml_adr !== '0 || fml_sel !== '0 || fml_do !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got stb=%b we=%b adr=%h sel=%h do=%h want all 0", fml_stb, fml_we, fml_adr, fml_sel, fml_do);
        end
        for (int i = 0; i < 8; i++) begin
            csr_read(3'(i), d);
            checks++;
            if (d !== 32'd0) begin
                errors++; $display("FAIL reset_csr%0d: got %h want 0", i, d);
            end
        end
    endtask

    task test_write;
        logic [31:0] d;
        prep(3, 1'b0, 32'd0);
        csr_write(REG_BASE, 32'h100);
        csr_write(REG_COUNT, 32'd2);
        csr_write(REG_SEED, 32'd0);
        q_req.push_back(26'h100);
        q_req.push_back(26'h120);
        for (int b = 0; b < 2; b++)
            for (int k = 0; k < 4; k++)
                q_wr.push_back((b == 0 && k == 1) ? 64'h00000108_FFFFFEF7 : pat(32'd0, 26'(32'h100 + 32 * b), k));
        csr_write(REG_CTRL, 32'h3);
        checks++;
        if (fml_stb !== 1'b1) begin
            errors++; $display("FAIL stb_rise: got %b want 1", fml_stb);
        end
        wait_idle;
        checks++;
        if (q_req.size() != 0 || q_wr.size() != 0) begin
            errors++; $display("FAIL wr_leftover: got req=%0d beats=%0d pending want 0", q_req.size(), q_wr.size());
        end
        csr_read(REG_CYCLES, d);
        checks++;
        if (d !== 32'(stb_cycles + 10)) begin
            errors++; $display("FAIL wr_cycles: got %0d want %0d", d, stb_cycles + 10);
        end
        csr_read(REG_ERRORS, d);
        checks++;
        if (d !== 32'd0) begin
            errors++; $display("FAIL wr_errors: got %0d want 0", d);
        end
        csr_read(REG_CTRL, d);
        checks++;
        if (d !== 32'h2) begin
            errors++; $display("FAIL wr_ctrl: got %h want 2", d);
        end
    endtask

    task test_read(input logic [63:0] mask, input int exp_err);
        logic [31:0] d;
        prep(3, 1'b1, 32'hA5A5_0F0F);
        corrupt = mask;
        csr_write(REG_BASE, 32'h100);
        csr_write(REG_COUNT, 32'd2);
        csr_write(REG_SEED, seed_tb);
        q_req.push_back(26'h100);
        q_req.push_back(26'h120);
        csr_write(REG_CTRL, 32'h1);
        wait_idle;
        csr_read(REG_ERRORS, d);
        checks++;
        if (d !== 32'(exp_err)) begin
            errors++; $display("FAIL rd_errors: got %0d want %0d", d, exp_err);
        end
        checks++;
        if (q_req.size() != 0 || gbeat != 8) begin
            errors++; $display("FAIL rd_bursts: got req_left=%0d beats=%0d want 0 and 8", q_req.size(), gbeat);
        end
    endtask

    task test_wrap;
        logic [31:0] d;
        prep(1, 1'b0, 32'hDEADBEEF);
        csr_write(REG_BASE, 32'h3FF_FFE0);
        csr_write(REG_COUNT, 32'd2);
        csr_write(REG_SEED, seed_tb);
        q_req.push_back(26'h3FF_FFE0);
        q_req.push_back(26'h0);
        for (int k = 0; k < 4; k++) q_wr.push_back(pat(seed_tb, 26'h3FF_FFE0, k));
        for (int k = 0; k < 4; k++) q_wr.push_back(pat(seed_tb, 26'h0, k));
        csr_write(REG_CTRL, 32'h3);
        wait_idle;
        checks++;
        if (q_req.size() != 0 || q_wr.size() != 0) begin
            errors++; $display("FAIL wrap_leftover: got req=%0d beats=%0d pending want 0", q_req.size(), q_wr.size());
        end
        checks++;
        if (ack_cyc.size() != 2 || ack_cyc[1] - ack_cyc[0] != 5) begin
            errors++; $display("FAIL b2b_period: got %0d acks want 2 acks 5 cycles apart", ack_cyc.size());
        end
        csr_read(REG_CYCLES, d);
        checks++;
        if (d !== 32'd12) begin
            errors++; $display("FAIL wrap_cycles: got %0d want 12", d);
        end
    endtask

    task test_abort_req;
        logic [31:0] d;
        logic [2:0] seen;
        prep(1000, 1'b0, 32'd0);
        csr_write(REG_BASE, 32'h40);
        csr_write(REG_COUNT, 32'd3);
        csr_write(REG_CTRL, 32'h3);
        repeat (2) begin @(posedge clk); #1; end
        checks++;
        if (fml_stb !== 1'b1) begin
            errors++; $display("FAIL abort_req_pre: got stb=%b want 1", fml_stb);
        end
        csr_write(REG_CTRL, 32'h4);
        checks++;
        if (fml_stb !== 1'b0) begin
            errors++; $display("FAIL abort_req_stb: got stb=%b want 0", fml_stb);
        end
        for (int i = 0; i < 3; i++) begin
            csr_read(REG_CTRL, d);
            seen[2 - i] = d[0];
        end
        checks++;
        if (seen !== 3'b110) begin
            errors++; $display("FAIL abort_req_busy: got busy seq %b want 110", seen);
        end
        csr_read(REG_CYCLES, d);
        checks++;
        if (d !== 32'(stb_cycles + 2) || gbeat != 0) begin
            errors++; $display("FAIL abort_req_cycles: got %0d beats=%0d want %0d beats=0", d, gbeat, stb_cycles + 2);
        end
    endtask

    task test_abort_data;
        logic [31:0] d;
        prep(1, 1'b0, 32'h1234_5678);
        csr_write(REG_BASE, 32'h200);
        csr_write(REG_COUNT, 32'd4);
        csr_write(REG_SEED, seed_tb);
        q_req.push_back(26'h200);
        for (int k = 0; k < 4; k++) q_wr.push_back(pat(seed_tb, 26'h200, k));
        csr_write(REG_CTRL, 32'h3);
        @(posedge clk); #1;
        csr_write(REG_CTRL, 32'h4);
        wait_idle;
        checks++;
        if (q_wr.size() != 0 || gbeat != 4) begin
            errors++; $display("FAIL abort_data_beats: got %0d beats want 4", gbeat);
        end
        csr_read(REG_CYCLES, d);
        checks++;
        if (d !== 32'd7) begin
            errors++; $display("FAIL abort_data_cycles: got %0d want 7", d);
        end
    endtask

    task test_reset_mid;
        logic [31:0] d;
        prep(1000, 1'b0, 32'd0);
        csr_write(REG_BASE, 32'h80);
        csr_write(REG_COUNT, 32'd5);
        csr_write(REG_SEED, 32'h55);
        csr_write(REG_CTRL, 32'h3);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (fml_stb !== 1'b0) begin
            errors++; $display("FAIL reset_mid_stb: got %b want 0", fml_stb);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        ack_lat = 1;
        for (int i = 0; i < 8; i++) begin
            csr_read(3'(i), d);
            checks++;
            if (d !== 32'd0) begin
                errors++; $display("FAIL reset_mid_csr%0d: got %h want 0", i, d);
            end
        end
    endtask

    task test_count_zero;
        logic [31:0] d;
        csr_write(REG_CTRL, 32'h1);
        checks++;
        if (fml_stb !== 1'b0) begin
            errors++; $display("FAIL count_zero_stb: got %b want 0", fml_stb);
        end
        csr_read(REG_CTRL, d);
        checks++;
        if (d !== 32'd0) begin
            errors++; $display("FAIL count_zero_busy: got %h want 0", d);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        test_reset;
        test_write;
        test_read(64'h0, 0);
        test_read(64'h0000_0000_0000_00F2, 5);
        test_wrap;
        test_abort_req;
        test_abort_data;
        test_reset_mid;
        test_count_zero;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
